// File: rtl/fp_issue_pkg.sv
// Shared types for the FP issue queue: tracking-entry layout, tag type and status width.
package fp_issue_pkg;

    localparam int unsigned STATUS_W  = 5;
    // Widest register address and tag the entry/tag types can hold (NUM_FREGS <= 32, DEPTH <= 16)
    localparam int unsigned MAX_AW    = 5;
    localparam int unsigned MAX_TAG_W = 4;

    typedef logic [MAX_TAG_W-1:0] tag_t;

    typedef struct packed {
        logic              valid;
        logic              rd_we;
        logic [MAX_AW-1:0] rd_addr;
    } entry_t;

endpackage

// File: rtl/fp_scoreboard.sv
// Per-register pending bits for FP destinations still in flight, plus RAW/WAW hazard detection.
module fp_scoreboard #(
    parameter int unsigned NUM_FREGS = 32,
    parameter int unsigned AW        = $clog2(NUM_FREGS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic [3*AW-1:0] rs_addr_i,
    input  logic [2:0]      rs_used_i,
    input  logic [AW-1:0]   rd_addr_i,
    input  logic            rd_we_i,
    input  logic            set_i,
    input  logic            clr_i,
    input  logic [AW-1:0]   clr_addr_i,
    output logic            hazard_o
);
    import fp_issue_pkg::*;

    logic [NUM_FREGS-1:0] pending_q, pending_d;

    // Hazard reads the pre-update pending bits, so a same-cycle completion still stalls.
    always_comb begin
        hazard_o = rd_we_i && pending_q[rd_addr_i];
        for (int i = 0; i < 3; i++) begin
            if (rs_used_i[i] && pending_q[rs_addr_i[i*AW +: AW]]) begin
                hazard_o = 1'b1;
            end
        end
    end

    // Next pending state: completion clears, accept sets, flush wipes everything.
    always_comb begin
        pending_d = pending_q;
        if (clr_i) pending_d[clr_addr_i] = 1'b0;
        if (set_i) pending_d[rd_addr_i] = 1'b1;
        if (clear_i) pending_d = '0;
    end

    // Pending-bit register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) pending_q <= '0;
        else         pending_q <= pending_d;
    end

endmodule

// File: rtl/fp_issue_queue.sv
// FP issue queue: issues decoded FP ops to an FPU with tags, stalls on register hazards, and
// routes out-of-order FPU results back to the FP register file.
// Optional feature: define FP_STATUS_ACCUM_EN to accumulate FPU status into sticky fflags_o.
module fp_issue_queue
    import fp_issue_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned NUM_FREGS = 32,
    parameter int unsigned TAG_W     = $clog2(DEPTH),
    parameter int unsigned AW        = $clog2(NUM_FREGS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                core_valid_i,
    output logic                issue_ready_o,
    input  logic [3*AW-1:0]     rs_addr_i,
    input  logic [2:0]          rs_used_i,
    input  logic [AW-1:0]       rd_addr_i,
    input  logic                rd_we_i,
    output logic                fpu_in_valid_o,
    input  logic                fpu_in_ready_i,
    output logic [TAG_W-1:0]    fpu_tag_o,
    input  logic                fpu_out_valid_i,
    output logic                fpu_out_ready_o,
    input  logic [TAG_W-1:0]    fpu_tag_i,
    input  logic [31:0]         fpu_result_i,
    input  logic [STATUS_W-1:0] fpu_status_i,
    output logic                wb_valid_o,
    output logic [AW-1:0]       wb_addr_o,
    output logic [31:0]         wb_data_o,
    input  logic                flush_i,
    output logic                fpu_flush_o,
    output logic                busy_o,
    output logic [STATUS_W-1:0] fflags_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t               entries_q [DEPTH];
    entry_t               entries_d [DEPTH];
    logic   [CNT_W-1:0]   count_q, count_d;
    logic   [TAG_W-1:0]   alloc_tag;
    entry_t               cpl_entry;
    logic                 full, hazard, accept, cpl_live;
    logic                 wb_valid_q;
    logic   [AW-1:0]      wb_addr_q;
    logic   [31:0]        wb_data_q;

    fp_scoreboard #(
        .NUM_FREGS (NUM_FREGS),
        .AW        (AW)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (flush_i),
        .rs_addr_i  (rs_addr_i),
        .rs_used_i  (rs_used_i),
        .rd_addr_i  (rd_addr_i),
        .rd_we_i    (rd_we_i),
        .set_i      (accept && rd_we_i),
        .clr_i      (cpl_live && cpl_entry.rd_we),
        .clr_addr_i (AW'(cpl_entry.rd_addr)),
        .hazard_o   (hazard)
    );

    assign full            = (count_q == CNT_W'(DEPTH));
    assign issue_ready_o   = rst_ni && fpu_in_ready_i && !full && !hazard && !flush_i;
    assign fpu_in_valid_o  = rst_ni && core_valid_i && !full && !hazard && !flush_i;
    assign accept          = core_valid_i && issue_ready_o;
    assign fpu_out_ready_o = 1'b1;
    assign fpu_flush_o     = flush_i;
    assign busy_o          = (count_q != '0);
    assign cpl_entry       = entries_q[fpu_tag_i];
    // Results for freed or never-issued tags are dropped; flush discards same-cycle results.
    assign cpl_live        = fpu_out_valid_i && cpl_entry.valid && !flush_i;
    assign fpu_tag_o       = alloc_tag;
    assign wb_valid_o      = wb_valid_q;
    assign wb_addr_o       = wb_addr_q;
    assign wb_data_o       = wb_data_q;

    // Lowest-index free tag; the completing tag is still busy here, so no alloc/free clash.
    always_comb begin
        alloc_tag = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!entries_q[i].valid) alloc_tag = TAG_W'(i);
        end
    end

    // Next entry table and occupancy count.
    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        if (cpl_live) begin
            entries_d[fpu_tag_i] = '0;
            count_d              = count_d - 1'b1;
        end
        if (accept) begin
            entries_d[alloc_tag] = '{valid: 1'b1, rd_we: rd_we_i, rd_addr: MAX_AW'(rd_addr_i)};
            count_d              = count_d + 1'b1;
        end
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) entries_d[i] = '0;
            count_d = '0;
        end
    end

    // Entry table and count registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

    // Writeback port, registered one cycle after a live completion.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= cpl_live && cpl_entry.rd_we;
            if (cpl_live) begin
                wb_addr_q <= AW'(cpl_entry.rd_addr);
                wb_data_q <= fpu_result_i;
            end
        end
    end

`ifdef FP_STATUS_ACCUM_EN
    logic [STATUS_W-1:0] fflags_q;

    // Sticky exception flags; only reset clears them, flush leaves them intact.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)       fflags_q <= '0;
        else if (cpl_live) fflags_q <= fflags_q | fpu_status_i;
    end

    assign fflags_o = fflags_q;
`else
    logic [STATUS_W-1:0] unused_status;
    assign unused_status = fpu_status_i;
    assign fflags_o      = '0;
`endif

endmodule

// File: tb/tb_fp_issue_queue.sv
// Directed bench for fp_issue_queue (DEPTH=4, NUM_FREGS=32): vector table plus corner sequences.
module tb_fp_issue_queue;

    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            core_valid_i;
    logic            issue_ready_o;
    logic [3*AW-1:0] rs_addr_i;
    logic [2:0]      rs_used_i;
    logic [AW-1:0]   rd_addr_i;
    logic            rd_we_i;
    logic            fpu_in_valid_o;
    logic            fpu_in_ready_i;
    logic [1:0]      fpu_tag_o;
    logic            fpu_out_valid_i;
    logic            fpu_out_ready_o;
    logic [1:0]      fpu_tag_i;
    logic [31:0]     fpu_result_i;
    logic [4:0]      fpu_status_i;
    logic            wb_valid_o;
    logic [AW-1:0]   wb_addr_o;
    logic [31:0]     wb_data_o;
    logic            flush_i;
    logic            fpu_flush_o;
    logic            busy_o;
    logic [4:0]      fflags_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_issue_queue dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .core_valid_i    (core_valid_i),
        .issue_ready_o   (issue_ready_o),
        .rs_addr_i       (rs_addr_i),
        .rs_used_i       (rs_used_i),
        .rd_addr_i       (rd_addr_i),
        .rd_we_i         (rd_we_i),
        .fpu_in_valid_o  (fpu_in_valid_o),
        .fpu_in_ready_i  (fpu_in_ready_i),
        .fpu_tag_o       (fpu_tag_o),
        .fpu_out_valid_i (fpu_out_valid_i),
        .fpu_out_ready_o (fpu_out_ready_o),
        .fpu_tag_i       (fpu_tag_i),
        .fpu_result_i    (fpu_result_i),
        .fpu_status_i    (fpu_status_i),
        .wb_valid_o      (wb_valid_o),
        .wb_addr_o       (wb_addr_o),
        .wb_data_o       (wb_data_o),
        .flush_i         (flush_i),
        .fpu_flush_o     (fpu_flush_o),
        .busy_o          (busy_o),
        .fflags_o        (fflags_o)
    );

    typedef struct {
        logic        cv;
        logic        rd_we;
        logic [4:0]  rd;
        logic [4:0]  rs_a;
        logic [2:0]  used;
        logic        ov;
        logic [1:0]  otag;
        logic [31:0] res;
        logic        e_ready;
        logic [1:0]  e_tag;
        logic        e_wbv;
        logic [4:0]  e_wba;
        logic [31:0] e_wbd;
        logic        e_busy;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(logic cv, logic rd_we, logic [4:0] rd, logic [4:0] rs_a,
                                logic [2:0] used, logic ov, logic [1:0] otag, logic [31:0] res,
                                logic e_ready, logic [1:0] e_tag, logic e_wbv, logic [4:0] e_wba,
                                logic [31:0] e_wbd, logic e_busy);
        vec_t v;
        v.cv = cv; v.rd_we = rd_we; v.rd = rd; v.rs_a = rs_a; v.used = used;
        v.ov = ov; v.otag = otag; v.res = res; v.e_ready = e_ready; v.e_tag = e_tag;
        v.e_wbv = e_wbv; v.e_wba = e_wba; v.e_wbd = e_wbd; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        core_valid_i = 0; rd_we_i = 0; rd_addr_i = 0; rs_addr_i = '0; rs_used_i = 0;
        fpu_in_ready_i = 1; fpu_out_valid_i = 0; fpu_tag_i = 0; fpu_result_i = 0;
        fpu_status_i = 0; flush_i = 0;
    endtask

    task automatic issue(input logic [4:0] rd);
        core_valid_i = 1; rd_we_i = 1; rd_addr_i = rd;
    endtask

    task automatic complete(input logic [1:0] tag, input logic [31:0] res, input logic [4:0] st);
        fpu_out_valid_i = 1; fpu_tag_i = tag; fpu_result_i = res; fpu_status_i = st;
    endtask

    // Advance one clock and leave time 1 unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] exp_fflags;

    initial begin
        //            cv we rd  rsa used ov tag res           rdy tag wbv wba wbd          busy
        vecs[0]  = mk(1, 1, 5,  0, 0,   0, 0, 32'h0,         1,  0,  0,  0,  32'h0,        1);
        vecs[1]  = mk(0, 0, 0,  0, 0,   1, 0, 32'h40400000,  1,  1,  1,  5,  32'h40400000, 0);
        vecs[2]  = mk(0, 0, 0,  0, 0,   0, 0, 32'h0,         1,  0,  0,  0,  32'h0,        0);
        vecs[3]  = mk(1, 1, 3,  0, 0,   0, 0, 32'h0,         1,  0,  0,  0,  32'h0,        1);
        vecs[4]  = mk(1, 1, 7,  3, 1,   0, 0, 32'h0,         0,  1,  0,  0,  32'h0,        1);
        vecs[5]  = mk(1, 1, 7,  3, 1,   1, 0, 32'h3F800000,  0,  1,  1,  3,  32'h3F800000, 0);
        vecs[6]  = mk(1, 1, 7,  3, 1,   0, 0, 32'h0,         1,  0,  0,  0,  32'h0,        1);
        vecs[7]  = mk(0, 0, 0,  0, 0,   1, 0, 32'h11111111,  1,  1,  1,  7,  32'h11111111, 0);
        vecs[8]  = mk(1, 1, 10, 0, 0,   0, 0, 32'h0,         1,  0,  0,  0,  32'h0,        1);
        vecs[9]  = mk(1, 1, 11, 0, 0,   0, 0, 32'h0,         1,  1,  0,  0,  32'h0,        1);
        vecs[10] = mk(0, 0, 0,  0, 0,   1, 1, 32'hAAAA0000,  1,  2,  1,  11, 32'hAAAA0000, 1);
        vecs[11] = mk(0, 0, 0,  0, 0,   1, 0, 32'hBBBB0000,  1,  1,  1,  10, 32'hBBBB0000, 0);
        vecs[12] = mk(0, 0, 0,  0, 0,   1, 2, 32'hDEADBEEF,  1,  0,  0,  0,  32'h0,        0);
        vecs[13] = mk(1, 0, 4,  0, 0,   0, 0, 32'h0,         1,  0,  0,  0,  32'h0,        1);
        vecs[14] = mk(0, 0, 0,  0, 0,   1, 0, 32'h12345678,  1,  1,  0,  0,  32'h0,        0);

        idle();
        rst_ni = 0;
        #1;
        check("ready_in_reset", {31'b0, issue_ready_o}, 0);
        check("in_valid_in_reset", {31'b0, fpu_in_valid_o}, 0);
        tick();
        tick();
        check("rst_wb_valid", {31'b0, wb_valid_o}, 0);
        check("rst_busy", {31'b0, busy_o}, 0);
        check("rst_fflags", {27'b0, fflags_o}, 0);
        check("out_ready", {31'b0, fpu_out_ready_o}, 1);
        @(negedge clk);
        rst_ni = 1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            idle();
            core_valid_i = vecs[i].cv; rd_we_i = vecs[i].rd_we; rd_addr_i = vecs[i].rd;
            rs_addr_i = {10'b0, vecs[i].rs_a}; rs_used_i = vecs[i].used;
            fpu_out_valid_i = vecs[i].ov; fpu_tag_i = vecs[i].otag; fpu_result_i = vecs[i].res;
            #1;
            check($sformatf("v%0d_ready", i), {31'b0, issue_ready_o}, {31'b0, vecs[i].e_ready});
            check($sformatf("v%0d_in_valid", i), {31'b0, fpu_in_valid_o},
                  {31'b0, vecs[i].e_ready & vecs[i].cv});
            check($sformatf("v%0d_tag", i), {30'b0, fpu_tag_o}, {30'b0, vecs[i].e_tag});
            tick();
            check($sformatf("v%0d_wb_valid", i), {31'b0, wb_valid_o}, {31'b0, vecs[i].e_wbv});
            if (vecs[i].e_wbv) begin
                check($sformatf("v%0d_wb_addr", i), {27'b0, wb_addr_o}, {27'b0, vecs[i].e_wba});
                check($sformatf("v%0d_wb_data", i), wb_data_o, vecs[i].e_wbd);
            end
            check($sformatf("v%0d_busy", i), {31'b0, busy_o}, {31'b0, vecs[i].e_busy});
        end

        // Fill all four tags, then a fifth issue must stall.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle();
            issue(5'(i + 1));
            #1;
            check($sformatf("fill%0d_ready", i), {31'b0, issue_ready_o}, 1);
            check($sformatf("fill%0d_tag", i), {30'b0, fpu_tag_o}, i);
            tick();
        end
        @(negedge clk);
        idle();
        issue(20);
        #1;
        check("full_ready", {31'b0, issue_ready_o}, 0);
        check("full_in_valid", {31'b0, fpu_in_valid_o}, 0);
        tick();

        // Free tag 2 (rd 3); the next issue reuses it.
        @(negedge clk);
        idle();
        complete(2, 32'h22222222, 5'b00001);
        tick();
        check("cpl2_wb_valid", {31'b0, wb_valid_o}, 1);
        check("cpl2_wb_addr", {27'b0, wb_addr_o}, 3);
        @(negedge clk);
        idle();
        issue(20);
        #1;
        check("reuse_ready", {31'b0, issue_ready_o}, 1);
        check("reuse_tag", {30'b0, fpu_tag_o}, 2);
        tick();

        // Drop to three outstanding, then flush with a same-cycle result.
        @(negedge clk);
        idle();
        complete(0, 32'h00000000, 5'b10000);
        tick();
        check("cpl0_wb_addr", {27'b0, wb_addr_o}, 1);
        check("three_busy", {31'b0, busy_o}, 1);
        @(negedge clk);
        idle();
        flush_i = 1;
        issue(9);
        complete(1, 32'hFFFF0000, 5'b00100);
        #1;
        check("flush_out", {31'b0, fpu_flush_o}, 1);
        check("flush_ready", {31'b0, issue_ready_o}, 0);
        tick();
        check("flush_wb_valid", {31'b0, wb_valid_o}, 0);
        check("flush_busy", {31'b0, busy_o}, 0);
`ifdef FP_STATUS_ACCUM_EN
        exp_fflags = 5'b10001;
`else
        exp_fflags = 5'b00000;
`endif
        check("flush_fflags", {27'b0, fflags_o}, {27'b0, exp_fflags});

        // Pending bits cleared by flush: rd 1 issues at tag 0.
        @(negedge clk);
        idle();
        issue(1);
        #1;
        check("post_flush_ready", {31'b0, issue_ready_o}, 1);
        check("post_flush_tag", {30'b0, fpu_tag_o}, 0);
        tick();

        // Reset while tag 0 completes: result discarded.
        @(negedge clk);
        idle();
        rst_ni = 0;
        complete(0, 32'h55555555, 5'b00010);
        #1;
        check("midrst_ready", {31'b0, issue_ready_o}, 0);
        tick();
        check("midrst_wb_valid", {31'b0, wb_valid_o}, 0);
        check("midrst_busy", {31'b0, busy_o}, 0);
        check("midrst_fflags", {27'b0, fflags_o}, 0);
        check("midrst_wb_data", wb_data_o, 0);
        @(negedge clk);
        idle();
        rst_ni = 1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_issue_queue.md
FP_ISSUE_QUEUE -- requirements
Module: fp_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning max outstanding FPU operations (power of two, 2..16).
REQ-002 SHALL have parameter NUM_FREGS, default 32, meaning FP register count; AW = $clog2(NUM_FREGS).
REQ-003 SHALL have parameter TAG_W, default $clog2(DEPTH), meaning FPU tag width.
REQ-004 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port core_valid_i  input  1  core presents a decoded FP operation.
REQ-007 SHALL have port issue_ready_o  output  1  operation accepted this cycle when high with core_valid_i.
REQ-008 SHALL have port rs_addr_i  input  3xAW  source register addresses a/b/c.
REQ-009 SHALL have port rs_used_i  input  3  per-source use flag.
REQ-010 SHALL have port rd_addr_i  input  AW  destination register; rd_we_i  input  1  writes FP register.
REQ-011 SHALL have ports fpu_in_valid_o out 1, fpu_in_ready_i in 1, fpu_tag_o out TAG_W: FPU input handshake.
REQ-012 SHALL have ports fpu_out_valid_i in 1, fpu_out_ready_o out 1, fpu_tag_i in TAG_W, fpu_result_i in 32, fpu_status_i in 5: FPU output side.
REQ-013 SHALL have ports wb_valid_o out 1, wb_addr_o out AW, wb_data_o out 32: FP register writeback.
REQ-014 SHALL have ports flush_i in 1, fpu_flush_o out 1, busy_o out 1, fflags_o out 5.

Function
REQ-015 SHALL assert hazard when any used source or (rd_we_i and rd_addr_i) has its pending bit set (RAW and WAW stall).
REQ-016 SHALL drive issue_ready_o = fpu_in_ready_i and not full and not hazard and not flush_i; fpu_in_valid_o = core_valid_i and same terms except fpu_in_ready_i (combinational).
REQ-017 SHALL, on accept, allocate the lowest-index free tag, drive it on fpu_tag_o, record {rd_we, rd_addr} in that entry, set rd pending bit (if rd_we_i), count+1.
REQ-018 SHALL hold fpu_out_ready_o = 1 permanently; results may return out of order and SHALL be matched by fpu_tag_i.
REQ-019 SHALL, on fpu_out_valid_i for a live tag, register wb_valid_o/wb_addr_o/wb_data_o one cycle later (latency 1), wb_valid_o only if entry rd_we, free the tag, clear rd pending bit, count-1.
REQ-020 SHALL ignore fpu_out_valid_i for a non-live tag (no writeback, no state change).
REQ-021 SHALL treat simultaneous accept and completion as count unchanged; an issue whose rd/rs matches the completing entry SHALL still stall that cycle (pending bits read pre-update).
REQ-022 SHALL assert full when count == DEPTH; busy_o = (count != 0).
REQ-023 SHALL, on flush_i, drive fpu_flush_o = 1 same cycle, clear all entries, pending bits and count next edge, discard any same-cycle result (no wb_valid_o).

Reset
REQ-024 SHALL, when rst_ni low at a rising edge, clear all entries, pending bits, count, wb_valid_o, wb_addr_o, wb_data_o, fflags_o to 0; mid-operation reset discards in-flight results.
REQ-025 SHALL hold issue_ready_o and fpu_in_valid_o low while rst_ni low.

Configuration
REQ-026 SHALL, with FP_STATUS_ACCUM_EN defined, OR fpu_status_i of each live completion into sticky fflags_o (cleared by reset only, not flush).
REQ-027 SHALL, without FP_STATUS_ACCUM_EN, tie fflags_o to 0 and omit the register.

Structure
REQ-028 SHALL place the entry typedef {valid, rd_we, rd_addr}, tag type and status width constant in shared package fp_issue_pkg.
REQ-029 SHALL implement pending-bit tracking and hazard detection in sub-module fp_scoreboard.

Verification
REQ-030 SHALL cover: single FADD rd=5, result 0x40400000 tag 0 -> wb_valid_o next cycle, wb_addr_o=5, wb_data_o=0x40400000, busy_o=0 after.
REQ-031 SHALL cover: issue rd=3 then op with rs_a=3 -> issue_ready_o=0 until tag-0 completion cycle +1, then accepted.
REQ-032 SHALL cover: DEPTH=4 issues, no completions -> issue_ready_o=0 on 5th; complete tag 2 -> next issue gets tag 2.
REQ-033 SHALL cover: completions tags 1 then 0 (out of order) -> writebacks to respective rd in that order, correct data.
REQ-034 SHALL cover: 3 outstanding then flush_i, same-cycle result -> fpu_flush_o=1, no wb_valid_o, count=0, busy_o=0.
REQ-035 SHALL cover: FP_STATUS_ACCUM_EN, statuses 5'b00001 then 5'b10000 -> fflags_o=5'b10001; unchanged after flush.
